// File: rtl/spi_master_transmit.sv
// SPI master transmitter: serialises one WIDTH-bit word per valid/ready handshake, MSB first.
// Define SPI_LOAD_STROBE_EN to add the 'load' frame-commit output, asserted through the gap window.
module spi_master_transmit #(
  parameter int DIV_HALF   = 4,
  parameter int GAP_CYCLES = 8,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             sck,
  output logic             sdi,
  output logic             busy,
  output logic             done
`ifdef SPI_LOAD_STROBE_EN
  ,
  output logic             load
`endif
);

  localparam int              BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [7:0]      DIV_LAST = 8'(DIV_HALF - 1);
  localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES);
  localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);
  localparam logic            GAP_NONE = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} state_t;

  state_t           state, state_d;
  // The current bit lives in sdi; shreg holds only the bits still to be sent.
  logic [WIDTH-2:0] shreg, shreg_d;
  logic [BW-1:0]    bitcnt, bitcnt_d;
  logic [7:0]       divcnt, divcnt_d;
  logic [7:0]       gapcnt, gapcnt_d;
  logic             ready_d, sck_d, sdi_d, busy_d, done_d;
`ifdef SPI_LOAD_STROBE_EN
  logic             load_d;
`endif

  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    bitcnt_d = bitcnt;
    divcnt_d = divcnt;
    gapcnt_d = gapcnt;
    ready_d  = ready;
    sck_d    = sck;
    sdi_d    = sdi;
    busy_d   = busy;
    done_d   = 1'b0;
`ifdef SPI_LOAD_STROBE_EN
    load_d   = load;
`endif
    case (state)
      IDLE: begin
        if (valid && ready) begin
          shreg_d  = data[WIDTH-2:0];
          sdi_d    = data[WIDTH-1];
          bitcnt_d = '0;
          divcnt_d = '0;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = LOW;
        end
      end
      LOW: begin
        if (divcnt == DIV_LAST) begin
          sck_d    = 1'b1;
          divcnt_d = '0;
          state_d  = HIGH;
        end else begin
          divcnt_d = divcnt + 8'd1;
        end
      end
      HIGH: begin
        if (divcnt == DIV_LAST) begin
          sck_d    = 1'b0;
          divcnt_d = '0;
          if (bitcnt == BIT_LAST) begin
            sdi_d    = 1'b0;
            gapcnt_d = '0;
            state_d  = GAP;
`ifdef SPI_LOAD_STROBE_EN
            // With no gap the strobe still needs its single commit cycle.
            load_d   = GAP_NONE;
`endif
          end else begin
            bitcnt_d = bitcnt + BW'(1);
            sdi_d    = shreg[WIDTH-2];
            shreg_d  = {shreg[WIDTH-3:0], 1'b0};
            state_d  = LOW;
          end
        end else begin
          divcnt_d = divcnt + 8'd1;
        end
      end
      GAP: begin
        if (gapcnt == GAP_LAST) begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef SPI_LOAD_STROBE_EN
          load_d  = 1'b0;
`endif
        end else begin
          gapcnt_d = gapcnt + 8'd1;
`ifdef SPI_LOAD_STROBE_EN
          load_d   = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      divcnt <= '0;
      gapcnt <= '0;
      ready  <= 1'b1;
      sck    <= 1'b0;
      sdi    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SPI_LOAD_STROBE_EN
      load   <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      shreg  <= shreg_d;
      bitcnt <= bitcnt_d;
      divcnt <= divcnt_d;
      gapcnt <= gapcnt_d;
      ready  <= ready_d;
      sck    <= sck_d;
      sdi    <= sdi_d;
      busy   <= busy_d;
      done   <= done_d;
`ifdef SPI_LOAD_STROBE_EN
      load   <= load_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_master_transmit.sv
// Directed bench for spi_master_transmit: a default-rate instance with a behavioural slave,
// and a DIV_HALF=1 / GAP_CYCLES=0 instance for bit timing and the optional load strobe.
module tb_spi_master_transmit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        ready_a, sck_a, sdi_a, busy_a, done_a;
  logic        ready_b, sck_b, sdi_b, busy_b, done_b;
`ifdef SPI_LOAD_STROBE_EN
  logic        load_a, load_b;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_master_transmit u_a (
    .clk(clk), .reset_n(reset_n), .data(data_a), .valid(valid_a), .ready(ready_a),
    .sck(sck_a), .sdi(sdi_a), .busy(busy_a), .done(done_a)
`ifdef SPI_LOAD_STROBE_EN
    , .load(load_a)
`endif
  );

  spi_master_transmit #(.DIV_HALF(1), .GAP_CYCLES(0), .WIDTH(32)) u_b (
    .clk(clk), .reset_n(reset_n), .data(data_b), .valid(valid_b), .ready(ready_b),
    .sck(sck_b), .sdi(sdi_b), .busy(busy_b), .done(done_b)
`ifdef SPI_LOAD_STROBE_EN
    , .load(load_b)
`endif
  );

  // Behavioural receive-only slave: shifts sdi in on every sck rise.
  logic [31:0] slave_q = '0;
  int          rises = 0;
  always @(posedge sck_a) begin
    slave_q = {slave_q[30:0], sdi_a};
    rises   = rises + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done_a(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done_a && cyc < 2000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          r0;
    int          rdy_hi;
    int          sck_err, sdi_err, hi_chg;
    logic        prev_sdi;
    logic [31:0] w;

    // Reset state
    tick(); tick();
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_sck",   32'(sck_a),   32'd0);
    check("rst_sdi",   32'(sdi_a),   32'd0);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_done",  32'(done_a),  32'd0);
    reset_n = 1'b1;
    tick();

    // Single frame
    data_a = 32'hA5C3_0F81; valid_a = 1'b1;
    r0 = rises;
    tick();
    valid_a = 1'b0;
    check("f1_ready_low", 32'(ready_a), 32'd0);
    check("f1_busy",      32'(busy_a),  32'd1);
    check("f1_sdi_msb",   32'(sdi_a),   32'd1);
    wait_done_a(cyc);
    check("f1_done_cycle", 32'(cyc), 32'd265);
    check("f1_rises",      32'(rises - r0), 32'd32);
    check("f1_slave_q",    slave_q, 32'hA5C3_0F81);
    check("f1_ready_back", 32'(ready_a), 32'd1);
    check("f1_busy_clr",   32'(busy_a),  32'd0);
    tick();
    check("f1_done_pulse", 32'(done_a), 32'd0);

    // Back-to-back with valid held high
    data_a = 32'h1234_5678; valid_a = 1'b1;
    tick();
    data_a = 32'hFFFF_0000;
    r0 = rises;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!ready_a && cyc < 2000);
    check("b2b_ready_cycle", 32'(cyc), 32'd265);
    check("b2b_done1",       32'(done_a), 32'd1);
    check("b2b_slave_q1",    slave_q, 32'h1234_5678);
    check("b2b_rises1",      32'(rises - r0), 32'd32);
    tick();
    valid_a = 1'b0;
    check("b2b_accept2", 32'(ready_a), 32'd0);
    check("b2b_busy2",   32'(busy_a),  32'd1);
    wait_done_a(cyc);
    check("b2b_done2_cycle", 32'(cyc), 32'd265);
    check("b2b_slave_q2",    slave_q, 32'hFFFF_0000);
    check("b2b_rises2",      32'(rises - r0), 32'd64);
    tick();

    // Inputs toggled while busy are ignored
    data_a = 32'h3C5A_9617; valid_a = 1'b1;
    tick();
    cyc = 0;
    rdy_hi = 0;
    while (cyc < 2000) begin
      valid_a = 1'($urandom_range(0, 1));
      data_a  = $urandom;
      tick();
      cyc++;
      if (done_a) break;
      if (ready_a) rdy_hi++;
    end
    valid_a = 1'b0;
    check("ign_done_cycle", 32'(cyc), 32'd265);
    check("ign_ready_low",  32'(rdy_hi), 32'd0);
    check("ign_slave_q",    slave_q, 32'h3C5A_9617);
    tick();

    // Reset mid-frame after 10 sck rises
    data_a = 32'h0F0F_1234; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    r0 = rises;
    cyc = 0;
    while ((rises - r0) < 10 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("mid_rises", 32'(rises - r0), 32'd10);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_sck",   32'(sck_a),   32'd0);
    check("mid_sdi",   32'(sdi_a),   32'd0);
    check("mid_ready", 32'(ready_a), 32'd1);
    check("mid_busy",  32'(busy_a),  32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    data_a = 32'h0000_00FF; valid_a = 1'b1;
    r0 = rises;
    tick();
    valid_a = 1'b0;
    check("mid_new_sdi_msb", 32'(sdi_a), 32'd0);
    wait_done_a(cyc);
    check("mid_new_cycle",   32'(cyc), 32'd265);
    check("mid_new_rises",   32'(rises - r0), 32'd32);
    check("mid_new_slave_q", slave_q, 32'h0000_00FF);
    tick();

    // Bit timing on the DIV_HALF=1, GAP_CYCLES=0 instance
    w = 32'h8000_0001;
    data_b = w; valid_b = 1'b1;
    tick();
    valid_b = 1'b0;
    sck_err = 0; sdi_err = 0; hi_chg = 0;
    prev_sdi = sdi_b;
    for (int k = 0; k <= 64; k++) begin
      if (sck_b !== 1'(k % 2)) sck_err++;
      if (sdi_b !== ((k < 64) ? w[31 - k / 2] : 1'b0)) sdi_err++;
      if (k > 0 && sdi_b !== prev_sdi && sck_b) hi_chg++;
      prev_sdi = sdi_b;
`ifdef SPI_LOAD_STROBE_EN
      check("fast_load_window", 32'(load_b), 32'(k == 64));
`endif
      tick();
    end
    check("fast_sck_toggle", 32'(sck_err), 32'd0);
    check("fast_sdi_bits",   32'(sdi_err), 32'd0);
    check("fast_sdi_stable", 32'(hi_chg),  32'd0);
    check("fast_done",       32'(done_b),  32'd1);
    check("fast_ready",      32'(ready_b), 32'd1);
`ifdef SPI_LOAD_STROBE_EN
    check("fast_load_fall",  32'(load_b),  32'd0);
`endif
    tick();
    check("fast_done_pulse", 32'(done_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_transmit.md
Name: spi_master_transmit

Overview:
- Drives the 32-bit SPI frame that the keyboard's receive-only SPI slave shifts in.
  - Generates sck and sdi.
  - MSB first, data valid around the sck rising edge.
- Used as the FPGA-side transmitter in loopback and self-test builds.
- Also serves as the reference driver in the keyboard testbench.
- Accepts one 32-bit word per valid/ready handshake and serialises it at a divided clock rate.

Parameters:
- DIV_HALF, 4, clk cycles per sck half-period; legal range 1..255.
- GAP_CYCLES, 8, idle clk cycles after a frame's last sck fall before ready reasserts; legal range 0..255.
- WIDTH, 32, frame length in bits; must match the slave shift register.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- data  input  WIDTH  word to transmit; sampled only on accept
- valid  input  1  data is available
- ready  output  1  block can accept a word
- sck  output  1  SPI clock to slave; idles low
- sdi  output  1  serial data to slave, MSB first
- busy  output  1  frame or gap in progress
- done  output  1  one-cycle pulse when the frame's gap completes

Behaviour:
- Reset (asynchronous, reset_n=0):
  - sck=0, sdi=0, ready=1, busy=0, done=0.
  - Shift register and counters cleared; state=IDLE.
  - Reset mid-frame aborts immediately. The slave sees a truncated frame; no recovery sequencing.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, LOW, HIGH, GAP.
- IDLE:
  - ready=1, busy=0, sck=0.
  - Accept occurs on the edge where valid=1 and ready=1.
  - On accept: shreg<=data, sdi<=data[WIDTH-1], bitcnt<=0, divcnt<=0, ready<=0, busy<=1, state<=LOW.
  - valid while ready=0 is ignored. The source must hold data and valid until accepted.
- LOW:
  - sck=0; divcnt counts 0..DIV_HALF-1.
  - At divcnt=DIV_HALF-1: sck<=1, divcnt<=0, state<=HIGH.
  - The slave samples sdi on this rise; sdi has been stable for DIV_HALF cycles.
- HIGH:
  - sck=1; divcnt counts 0..DIV_HALF-1.
  - At terminal count: sck<=0, divcnt<=0.
  - If bitcnt=WIDTH-1: state<=GAP, sdi<=0.
  - Otherwise: bitcnt<=bitcnt+1, shreg shifts left one, sdi<=next bit, state<=LOW.
  - sdi changes only on the sck falling edge, never while sck=1.
- GAP:
  - sck=0, sdi=0; gapcnt counts GAP_CYCLES cycles.
  - Then done<=1 for one cycle, ready<=1, busy<=0, state<=IDLE.
  - If GAP_CYCLES=0: the transition to IDLE happens on the cycle after the last fall.
- Timing:
  - Frame length: WIDTH*2*DIV_HALF clk cycles from accept to the last sck fall.
  - Accept to ready reassert: WIDTH*2*DIV_HALF + GAP_CYCLES + 1 cycles.
  - Default values: 256 + 8 + 1 = 265 cycles.
- Back-to-back transfers: valid held high in the same cycle ready rises is accepted on that edge. The new frame's first LOW phase follows directly.
- Exactly WIDTH rising edges of sck per frame. After one frame, slave q equals the accepted data.
- bitcnt width: clog2(WIDTH). divcnt and gapcnt: 8 bits. Counters never wrap within legal parameter ranges.

Optional Feature:
- Macro: SPI_LOAD_STROBE_EN.
- When defined:
  - Adds output load (1 bit, reset 0).
  - load=1 during the final GAP_CYCLES window. If GAP_CYCLES=0, load is forced to one cycle.
  - The receiver uses it as a frame-commit strobe to latch q into its note/wave logic.
  - load falls the same cycle done pulses.
- When undefined:
  - No load port.
  - The receiver must time frame boundaries by counting sck edges or by quiet periods.

Test Plan:
- Reset idle, then single frame:
  - Stimulus: after reset_n release, data=32'hA5C3_0F81 with valid=1 for one cycle.
  - Required: ready=0 the next cycle; exactly 32 sck rises.
  - Required: a behavioural slave shift register captures 32'hA5C3_0F81.
  - Required: done pulses at cycle 265 after accept.
- Bit timing:
  - Stimulus: DIV_HALF=1, data=32'h8000_0001.
  - Required: sck toggles every clk.
  - Required: sdi=1 for the first bit only and for the last bit only.
  - Required: sdi never changes while sck=1.
- Back-to-back:
  - Stimulus: valid held high with data 32'h1234_5678 then 32'hFFFF_0000.
  - Required: second accept on the cycle ready rises.
  - Required: slave captures both words in order, with no extra sck edges between frames beyond the gap.
- Ignored input:
  - Stimulus: toggle valid and data randomly while busy=1.
  - Required: transmitted word unchanged; ready stays 0 until the gap ends.
- Reset mid-frame:
  - Stimulus: assert reset_n=0 after 10 sck rises.
  - Required: sck=0, sdi=0, ready=1 asynchronously (same cycle).
  - Required: a new frame 32'h0000_00FF then transmits correctly from bit 31.
- SPI_LOAD_STROBE_EN defined, GAP_CYCLES=0:
  - Required: load high exactly one cycle after the 32nd sck fall, coincident with the done cycle rule.
